exp_sqrt_lut_arbiter: RTL and testbench

//  Shares one sqrt(2^x) lookup (out = round(2^(in/2)*256), 7-bit signed in, 12-bit out) among N_REQ requesters.

---
 rtl/exp_sqrt_lut_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_exp_sqrt_lut_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_sqrt_lut_arbiter.sv
// rtl/exp_sqrt_lut_arbiter.sv - round-robin arbiter sharing one sqrt(2^x) LUT over a 2-stage pipeline (optional EXP_SQRT_ARB_STATS_EN adds sat/zero counters)
module exp_sqrt_lut_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [7*N_REQ-1:0] req_in,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [11:0]        rsp_data,
    output logic               busy
`ifdef EXP_SQRT_ARB_STATS_EN
    ,
    output logic [15:0]        sat_cnt,
    output logic [15:0]        zero_cnt
`endif
);

    // 256 * 2^(x/2) rounded; saturates high above 7, reaches zero below -18
    function automatic logic [11:0] lut(input logic signed [6:0] x);
        logic [6:0]  off;
        logic [11:0] r;
        off = x + 7'sd18;
        r   = 12'd0;
        if (x > 7'sd7) begin
            r = 12'd4095;
        end else if (x < -7'sd18) begin
            r = 12'd0;
        end else begin
            case (off[4:0])
                5'd0:    r = 12'd1;
                5'd1:    r = 12'd1;
                5'd2:    r = 12'd1;
                5'd3:    r = 12'd1;
                5'd4:    r = 12'd2;
                5'd5:    r = 12'd3;
                5'd6:    r = 12'd4;
                5'd7:    r = 12'd6;
                5'd8:    r = 12'd8;
                5'd9:    r = 12'd11;
                5'd10:   r = 12'd16;
                5'd11:   r = 12'd23;
                5'd12:   r = 12'd32;
                5'd13:   r = 12'd45;
                5'd14:   r = 12'd64;
                5'd15:   r = 12'd91;
                5'd16:   r = 12'd128;
                5'd17:   r = 12'd181;
                5'd18:   r = 12'd256;
                5'd19:   r = 12'd362;
                5'd20:   r = 12'd512;
                5'd21:   r = 12'd724;
                5'd22:   r = 12'd1024;
                5'd23:   r = 12'd1448;
                5'd24:   r = 12'd2048;
                5'd25:   r = 12'd2896;
                default: r = 12'd0;
            endcase
        end
        return r;
    endfunction

    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            s1_vld_q, s1_vld_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic [6:0]      s1_in_q, s1_in_d;
    logic            s2_vld_q, s2_vld_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;
    logic [11:0]     s2_data_q, s2_data_d;

    logic            adv1, adv2;
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [6:0]      grant_in;

    assign adv2      = ~s2_vld_q | rsp_ready;
    assign adv1      = ~s1_vld_q | adv2;
    assign rsp_valid = s2_vld_q;
    assign rsp_id    = s2_id_q;
    assign rsp_data  = s2_data_q;
    assign busy      = s1_vld_q | s2_vld_q;

    // Round-robin scan from rr_ptr; no grant while S1 cannot move, during flush or in reset
    always_comb begin
        int j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_in  = '0;
        req_ready = '0;
        if (rst_n && adv1 && !flush) begin
            for (int k = 0; k < N_REQ; k++) begin
                j = int'(rr_ptr_q) + k;
                if (j >= N_REQ) j = j - N_REQ;
                if (!grant_vld && req_valid[j]) begin
                    grant_vld = 1'b1;
                    grant_idx = ID_W'(j);
                    grant_in  = req_in[7*j +: 7];
                end
            end
        end
        if (grant_vld) req_ready = N_REQ'(1) << grant_idx;
    end

    // Pipeline advance, pointer update and flush; rsp_id/rsp_data only change when a real entry moves in
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        s1_vld_d  = s1_vld_q;
        s1_id_d   = s1_id_q;
        s1_in_d   = s1_in_q;
        s2_vld_d  = s2_vld_q;
        s2_id_d   = s2_id_q;
        s2_data_d = s2_data_q;
        if (adv2) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q && !flush) begin
                s2_id_d   = s1_id_q;
                s2_data_d = lut(s1_in_q);
            end
        end
        if (adv1) begin
            s1_vld_d = grant_vld;
            if (grant_vld) begin
                s1_id_d = grant_idx;
                s1_in_d = grant_in;
            end
        end
        if (grant_vld) begin
            rr_ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
        if (flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_id_q   <= '0;
            s1_in_q   <= '0;
            s2_vld_q  <= 1'b0;
            s2_id_q   <= '0;
            s2_data_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_id_q   <= s1_id_d;
            s1_in_q   <= s1_in_d;
            s2_vld_q  <= s2_vld_d;
            s2_id_q   <= s2_id_d;
            s2_data_q <= s2_data_d;
        end
    end

`ifdef EXP_SQRT_ARB_STATS_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;
    logic [15:0] zero_cnt_q, zero_cnt_d;

    assign sat_cnt  = sat_cnt_q;
    assign zero_cnt = zero_cnt_q;

    // Count accepted saturated / zero responses, sticking at all-ones
    always_comb begin
        sat_cnt_d  = sat_cnt_q;
        zero_cnt_d = zero_cnt_q;
        if (s2_vld_q && rsp_ready) begin
            if (s2_data_q == 12'd4095 && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
            if (s2_data_q == 12'd0 && zero_cnt_q != 16'hFFFF) zero_cnt_d = zero_cnt_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q  <= '0;
            zero_cnt_q <= '0;
        end else begin
            sat_cnt_q  <= sat_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_exp_sqrt_lut_arbiter.sv
// tb/tb_exp_sqrt_lut_arbiter.sv - self-checking bench for exp_sqrt_lut_arbiter
module tb_exp_sqrt_lut_arbiter;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [7*N-1:0] req_in = '0;
    logic [N-1:0]  req_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_id;
    logic [11:0]   rsp_data;
    logic          busy;
`ifdef EXP_SQRT_ARB_STATS_EN
    logic [15:0]   sat_cnt;
    logic [15:0]   zero_cnt;
`endif

    exp_sqrt_lut_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_in(req_in), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
`ifdef EXP_SQRT_ARB_STATS_EN
        , .sat_cnt(sat_cnt), .zero_cnt(zero_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: 256 * 2^(x/2), rounded half up, clipped to 12 bits
    function automatic int lut_model(input int x);
        real v;
        int  r;
        v = 256.0 * $pow(2.0, real'(x) / 2.0);
        r = $rtoi(v + 0.5);
        if (r > 4095) r = 4095;
        return r;
    endfunction

    typedef struct { int g; int id; int data; } ent_t;
    ent_t q[$];
    int   log_id[$];
    int   log_data[$];
    int   cyc = 0;
    int   last = N - 1;
    bit   stall_prev = 1'b0;
    int   prev_id, prev_data;
    int   m_sat = 0, m_zero = 0;

    // Compare process: outputs versus an occupancy/round-robin model, every cycle
    always @(negedge clk) begin
        int gi, j, exp_rr;
        bit exp_v;
        ent_t e;
        cyc++;
        if (!rst_n) begin
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_req_ready", req_ready, 0);
            check("rst_busy", busy, 0);
            check("rst_rsp_id", rsp_id, 0);
            check("rst_rsp_data", rsp_data, 0);
`ifdef EXP_SQRT_ARB_STATS_EN
            check("rst_sat_cnt", sat_cnt, 0);
            check("rst_zero_cnt", zero_cnt, 0);
`endif
            q.delete();
            last = N - 1;
            stall_prev = 1'b0;
            m_sat = 0;
            m_zero = 0;
        end else begin
            gi = -1;
            if (!flush && (q.size() < 2 || rsp_ready)) begin
                for (int k = 1; k <= N; k++) begin
                    j = (last + k) % N;
                    if (gi < 0 && req_valid[j]) gi = j;
                end
            end
            exp_rr = (gi < 0) ? 0 : (1 << gi);
            check("req_ready", req_ready, exp_rr);
            check("busy", busy, (q.size() > 0) ? 1 : 0);
            exp_v = (q.size() > 0) && (cyc >= q[0].g + 2);
            check("rsp_valid", rsp_valid, exp_v);
            if (stall_prev) begin
                check("stall_id", rsp_id, prev_id);
                check("stall_data", rsp_data, prev_data);
            end
`ifdef EXP_SQRT_ARB_STATS_EN
            check("sat_cnt", sat_cnt, m_sat);
            check("zero_cnt", zero_cnt, m_zero);
`endif
            if (exp_v && rsp_ready) begin
                check("rsp_id", rsp_id, q[0].id);
                check("rsp_data", rsp_data, q[0].data);
                log_id.push_back(int'(rsp_id));
                log_data.push_back(int'(rsp_data));
                if (q[0].data == 4095 && m_sat < 65535) m_sat++;
                if (q[0].data == 0 && m_zero < 65535) m_zero++;
                void'(q.pop_front());
            end
            if (gi >= 0) begin
                e.g = cyc;
                e.id = gi;
                e.data = lut_model(int'($signed(req_in[7*gi +: 7])));
                q.push_back(e);
                last = gi;
            end
            if (flush) q.delete();
            stall_prev = exp_v && !rsp_ready && !flush;
            prev_id = int'(rsp_id);
            prev_data = int'(rsp_data);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input int v);
        req_in[7*i +: 7] = 7'(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    task automatic load_mix();
        set_in(0, 7);
        set_in(1, 8);
        set_in(2, 64);
        set_in(3, 127);
    endtask

    initial begin
        int exp_mix [4];
        exp_mix[0] = 2896; exp_mix[1] = 4095; exp_mix[2] = 0; exp_mix[3] = 181;

        // Model anchors
        check("model_0", lut_model(0), 256);
        check("model_7", lut_model(7), 2896);
        check("model_8", lut_model(8), 4095);
        check("model_m18", lut_model(-18), 1);
        check("model_m19", lut_model(-19), 0);
        check("model_m1", lut_model(-1), 181);

        // 1: single request, two-cycle latency
        #1;
        do_reset();
        rsp_ready = 1'b1;
        set_in(0, 0);
        req_valid = 4'b0001;
        cycles(1);
        req_valid = '0;
        check("t1_lat1_valid", rsp_valid, 0);
        cycles(1);
        check("t1_valid", rsp_valid, 1);
        check("t1_id", rsp_id, 0);
        check("t1_data", rsp_data, 256);
        cycles(3);

        // 2: round-robin over all four, back-to-back
        do_reset();
        load_mix();
        log_id.delete(); log_data.delete();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        cycles(8);
        req_valid = '0;
        cycles(4);
        check("t2_count", log_id.size(), 8);
        for (int i = 0; i < log_id.size(); i++) begin
            check("t2_id", log_id[i], i % 4);
            check("t2_data", log_data[i], exp_mix[i % 4]);
        end

        // 3: backpressure, no loss, contiguous on release
        do_reset();
        load_mix();
        log_id.delete(); log_data.delete();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        cycles(2);
        check("t3_full_ready", req_ready, 0);
        check("t3_full_valid", rsp_valid, 1);
        cycles(2);
        check("t3_hold_id", rsp_id, 0);
        check("t3_hold_data", rsp_data, 2896);
        cycles(1);
        rsp_ready = 1'b1;
        cycles(8);
        req_valid = '0;
        cycles(4);
        check("t3_count", log_id.size(), 10);
        for (int i = 0; i < log_id.size(); i++) begin
            check("t3_seq_id", log_id[i], i % 4);
            check("t3_seq_data", log_data[i], exp_mix[i % 4]);
        end

        // 4: flush with both stages full; round-robin resumes at saved pointer
        do_reset();
        load_mix();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        cycles(2);
        flush = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("t4_flush_no_grant", req_ready, 0);
        cycles(1);
        flush = 1'b0;
        log_id.delete(); log_data.delete();
        #1;
        check("t4_after_valid", rsp_valid, 0);
        check("t4_after_busy", busy, 0);
        check("t4_resume_grant", req_ready, 4'b0100);
        cycles(4);
        req_valid = '0;
        cycles(4);
        check("t4_first_id", (log_id.size() > 0) ? log_id[0] : -1, 2);

        // 5: asynchronous reset mid-stream
        do_reset();
        load_mix();
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        cycles(3);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", rsp_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", req_ready, 0);
        check("t5_rst_id", rsp_id, 0);
        check("t5_rst_data", rsp_data, 0);
        req_valid = 4'b0100;
        set_in(2, 116);
        cycles(1);
        rst_n = 1'b1;
        #1;
        check("t5_grant", req_ready, 4'b0100);
        cycles(1);
        req_valid = '0;
        cycles(1);
        check("t5_valid", rsp_valid, 1);
        check("t5_id", rsp_id, 2);
        check("t5_data", rsp_data, 4);
        cycles(3);

`ifdef EXP_SQRT_ARB_STATS_EN
        // 6: saturation / zero counters, stalled response not counted
        do_reset();
        rsp_ready = 1'b0;
        set_in(0, 8);
        req_valid = 4'b0001;
        cycles(1);
        req_valid = '0;
        cycles(3);
        check("t6_stalled_sat", sat_cnt, 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(0, (i % 2 == 0) ? -30 : 8);
            req_valid = 4'b0001;
            cycles(1);
        end
        req_valid = '0;
        cycles(4);
        check("t6_sat", sat_cnt, 3);
        check("t6_zero", zero_cnt, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
